// File: rtl/operand_loader.sv
// Operand entry stage: debounced pushbutton steps through loading A, B and carry-in
// from the board switches and holds them on registered outputs for the adder.
module operand_loader #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic             cin_sw,
    input  logic             key_n,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             cin,
    output logic             operands_valid,
    output logic [1:0]       phase,
    output logic             load_pulse
);
    // state   | meaning
    // LOAD_A  | waiting for press to capture operand A
    // LOAD_B  | waiting for press to capture operand B and carry-in
    // SHOW    | complete operand set held, next press restarts
    // ILLEGAL | unreachable, recovers to LOAD_A without capture
    typedef enum logic [1:0] {
        LOAD_A  = 2'b00,
        LOAD_B  = 2'b01,
        SHOW    = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             key_s;
    logic             key_db;
    logic [CNT_W-1:0] cnt;
    logic             press;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_nx, b_nx;
    logic             cin_nx, valid_nx, pulse_nx;

    assign key_s = sync_q[1];

    // press is raised on the same edge the debounced level falls, so it is a
    // single-cycle event no matter how long the key stays down
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            key_db <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], key_n};
            press  <= 1'b0;
            if (key_s == key_db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                key_db <= key_s;
                cnt    <= '0;
                press  <= ~key_s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= LOAD_A;
            a              <= '0;
            b              <= '0;
            cin            <= 1'b0;
            operands_valid <= 1'b0;
            load_pulse     <= 1'b0;
        end else begin
            state          <= state_nx;
            a              <= a_nx;
            b              <= b_nx;
            cin            <= cin_nx;
            operands_valid <= valid_nx;
            load_pulse     <= pulse_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            LOAD_A:  if (press) state_nx = LOAD_B;
            LOAD_B:  if (press) state_nx = SHOW;
            SHOW:    if (press) state_nx = LOAD_A;
            default: state_nx = LOAD_A;
        endcase
    end

    always_comb begin
        a_nx     = a;
        b_nx     = b;
        cin_nx   = cin;
        valid_nx = 1'b0;
        pulse_nx = 1'b0;
        case (state)
            LOAD_A: begin
                if (press) begin
                    a_nx     = sw;
                    pulse_nx = 1'b1;
                end
            end
            LOAD_B: begin
                if (press) begin
                    b_nx     = sw;
                    cin_nx   = cin_sw;
                    valid_nx = 1'b1;
                    pulse_nx = 1'b1;
                end
            end
            SHOW:    valid_nx = ~press;
            default: valid_nx = 1'b0;
        endcase
    end

    assign phase = state;

endmodule

// File: doc/operand_loader.md
Name: operand_loader

Overview:
- Upstream operand-entry stage for the 8-bit adder/display datapath.
- Debounces a single pushbutton and uses it to step through loading operand A, operand B and carry-in from board switches.
- Holds the captured values on stable registered outputs that drive the adder's a, b and cin inputs directly.
- Flags when a complete operand set is present.

Parameters:
- WIDTH, 8, operand width in bits.
- DEBOUNCE_CYCLES, 500000, consecutive stable clocks required to accept a key level change (10 ms at 50 MHz). Legal range ≥ 2.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst_n  input  1  synchronous, active-low reset.
- sw  input  WIDTH  raw operand switches; quasi-static, sampled unsynchronised.
- cin_sw  input  1  raw carry-in switch; quasi-static.
- key_n  input  1  raw pushbutton, active-low (0 = pressed), asynchronous.
- a  output  WIDTH  captured operand A.
- b  output  WIDTH  captured operand B.
- cin  output  1  captured carry-in.
- operands_valid  output  1  high while A, B and cin form a complete set.
- phase  output  2  current FSM state, for LEDs.
- load_pulse  output  1  one-cycle strobe on every capture.

Behaviour:
- Reset, on a clk edge with rst_n=0, overrides everything, including mid-debounce and mid-sequence:
  - a=0, b=0, cin=0, operands_valid=0, load_pulse=0, phase=LOAD_A.
  - Synchroniser flops = 1, debounced level = 1 (released), debounce counter = 0.
- Synchroniser: key_n passes through 2 flops to give key_s.
- Debouncer:
  - Counter cnt, width clog2(DEBOUNCE_CYCLES).
  - If key_s == key_db: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: key_db <= key_s, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Net effect: key_db changes on the DEBOUNCE_CYCLES-th consecutive differing cycle. Any shorter glitch resets cnt and is ignored.
- Press event:
  - One-cycle internal pulse when key_db goes 1→0.
  - Release (0→1) is debounced the same way but produces no event.
  - A key held indefinitely gives exactly one event.
  - Latency from key_n falling to press event is 2 + DEBOUNCE_CYCLES clocks. Capture registers update on the following edge.
- FSM states and phase encodings:
  - LOAD_A (00): on press, a <= sw, load_pulse=1, go to LOAD_B.
  - LOAD_B (01): on press, b <= sw, cin <= cin_sw, operands_valid <= 1, load_pulse=1, go to SHOW.
  - SHOW (10): on press, operands_valid <= 0, go to LOAD_A. a, b and cin are retained; no load_pulse.
  - Encoding 11 is unreachable; if entered, go to LOAD_A on the next clock with no capture.
- Outputs:
  - All outputs are registered.
  - a, b and cin change only on their capture edge or on reset.
  - load_pulse is high for exactly one cycle per capture.
  - operands_valid is 1 only in SHOW.
- Key held through reset: after rst_n releases, the key is seen as a new press after 2 + DEBOUNCE_CYCLES clocks. This is required behaviour.
- sw/cin_sw are sampled on the single capture edge only. Values before or after that edge are irrelevant.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset with key_n=1 → a=0x00, b=0x00, cin=0, operands_valid=0, phase=00, load_pulse=0.
- Full sequence:
  - sw=0x3C, clean press/release → a=0x3C, phase=01, a single load_pulse.
  - Then sw=0xA5, cin_sw=1, press → b=0xA5, cin=1, operands_valid=1, phase=10.
  - Third press → operands_valid=0, phase=00, a=0x3C and b=0xA5 retained.
- Bounce: key_n low for 3 cycles, high 1, low 2, then low steady → exactly one capture. It occurs on the edge after the 4th consecutive low key_s cycle. Glitches of ≤3 cycles alone give no capture.
- Held key: key_n low for 1000 cycles in LOAD_A → exactly one load_pulse, phase stays 01.
- Reset mid-sequence: in LOAD_B with cnt=2, assert rst_n=0 for 1 cycle → all outputs at reset values, phase=00. The pending press produces no capture.
- Key held through reset → after rst_n=1 with key_n=0, capture of sw into a occurs exactly 2+4+1 clocks later.
